alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares the single 8-bit combinational ALU between two requesters: port 0 is the execute stage, port 1 is the branch/compare unit.
- Arbitrates round-robin and registers the winning operands and opcode.
- Drives the ALU through its own output ports, captures the ALU result and zero flag, and returns them to the winner over a valid/ready response channel.
- Keeps per-port saturating grant counters for performance debug.

Parameters:
- DATA_W, 8, operand/result width (matches ALU).
- OP_W, 3, ALU opcode width.
- CNT_W, 16, width of each per-port grant counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-port request valid.
- req_ready  out  2  per-port request accept.
- req_op  in  2xOP_W  per-port ALU opcode.
- req_a  in  2xDATA_W  per-port operand A.
- req_b  in  2xDATA_W  per-port operand B.
- rsp_valid  out  2  per-port response valid; only the owner's bit is ever high.
- rsp_ready  in  2  per-port response accept.
- rsp_data  out  DATA_W  result shared by both ports, qualified by rsp_valid.
- rsp_zero  out  1  captured ALU zero flag.
- alu_a  out  DATA_W  to ALU operand A.
- alu_b  out  DATA_W  to ALU operand B.
- alu_op  out  OP_W  to ALU opcode.
- alu_result  in  DATA_W  from ALU result.
- alu_zero  in  1  from ALU zero flag.
- busy  out  1  high when state != IDLE.
- grant_cnt  out  2xCNT_W  per-port accepted-request count, saturating.

Behaviour:
- Reset (async assert, sync deassert is the system's job): state=IDLE, rr_ptr=0 (port 0 has priority), all operand/op/result registers=0, owner=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_zero=0, busy=0, grant_cnt=0.
- States:
  - IDLE:
    - Grant is combinational from req_valid and rr_ptr.
    - req_ready[g]=1 only for the granted port g; the other bit is 0. Both bits are 0 outside IDLE.
    - When req_valid[g]=1: latch req_op/a/b[g] into op_q/a_q/b_q, owner<=g, rr_ptr<=~g, grant_cnt[g]++ (holds at all-ones), then go to EXEC.
  - EXEC (exactly 1 cycle):
    - alu_a/alu_b/alu_op are driven from a_q/b_q/op_q.
    - At the end of the cycle, capture alu_result->rsp_data and alu_zero->rsp_zero, then go to RESP.
  - RESP:
    - rsp_valid[owner]=1. rsp_data/rsp_zero are stable and held until the handshake.
    - On rsp_ready[owner]=1, go to IDLE. rsp_ready of the non-owner is ignored.
- ALU outputs always reflect a_q/b_q/op_q, including in IDLE/RESP, so there are no glitches from requester inputs.
- Latency: request handshake at edge N -> rsp_valid high from cycle N+2. Minimum 3 cycles per operation (IDLE, EXEC, RESP). No new request is accepted until the response handshake completes.
- Arbitration:
  - Only one request valid: that port wins regardless of rr_ptr.
  - Both valid: port rr_ptr wins; the loser keeps req_ready=0 and wins the next arbitration if it is still valid.
  - rr_ptr changes only on a grant.
- Requesters hold req_valid and payload stable until req_ready. Payload changes while not ready have no effect.
- Response backpressure: RESP may persist indefinitely. There is no timeout.
- Reset mid-operation: everything returns immediately to reset values and any in-flight result is discarded.
- Width rules:
  - The result is whatever the ALU returns, truncated to DATA_W (ADD wraps mod 256). The block never interprets the opcode.
  - grant_cnt saturates at 2^CNT_W-1 and does not wrap.

Decomposition:
- Shared package alu_pkg:
  - alu_op_e enum: AND=000, ADD=001, XOR=010, SLT=011, SLL=100, SRL=101, SNE=110, OVF=111.
  - arb_state_e enum: IDLE, EXEC, RESP.
  - Constants DATA_W and OP_W.
- One sub-module, rr_arb2: combinational 2-way round-robin grant (inputs valid[1:0] and ptr; outputs grant[1:0] one-hot and gnt_idx).
- The ALU stays a separate instance, wired at the datapath top level.

Test Plan:
- Port 0 only: ADD a=0x05, b=0x03 -> req_ready[0]=1 in the accept cycle; rsp_valid[0] two cycles later; rsp_data=0x08, rsp_zero=0; busy=1 for 2 cycles; grant_cnt[0]=1.
- Port 1 only: AND a=0xF0, b=0x0F -> rsp_valid[1] with rsp_data=0x00, rsp_zero=1; rsp_valid[0] stays 0 throughout.
- Both valid from reset: port 0 ADD 0xFF+0x02, port 1 SLT 0x03<0x07.
  - Port 0 is served first with rsp_data=0x01 (wrap).
  - Port 1 is served next with rsp_data=0x01.
  - Issue a third simultaneous pair: port 0 wins again (rr_ptr back to 0).
- Backpressure: hold rsp_ready[0]=0 for 10 cycles with port 1 valid.
  - rsp_data stays constant, state stays RESP and req_ready=0.
  - Assert rsp_ready[1] during this window: it has no effect.
  - Release rsp_ready[0]: IDLE, then port 1 is granted.
- Reset mid-EXEC: deassert reset_n asynchronously in EXEC.
  - All outputs go to 0 within the cycle.
  - After release, a new request completes normally and the discarded op never appears on rsp_valid.
- Counter saturation: CNT_W=4 build, 17 grants to port 0 -> grant_cnt[0]=0xF, and operation is otherwise unaffected.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU sharing arbiter and its environment.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    AND = 3'b000,
    ADD = 3'b001,
    XOR = 3'b010,
    SLT = 3'b011,
    SLL = 3'b100,
    SRL = 3'b101,
    SNE = 3'b110,
    OVF = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Two-port request/response bundle between the requesters and the ALU arbiter.
interface alu_share_arbiter_if;
  import alu_pkg::*;

  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0][OP_W-1:0]   req_op;
  logic [1:0][DATA_W-1:0] req_a;
  logic [1:0][DATA_W-1:0] req_b;
  logic [1:0]             rsp_valid;
  logic [1:0]             rsp_ready;
  logic [DATA_W-1:0]      rsp_data;
  logic                   rsp_zero;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_zero
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_zero
  );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant; ptr only matters when both ports request.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant,
  output logic       gnt_idx
);

  always_comb begin
    gnt_idx = ptr;
    if (valid == 2'b01) begin
      gnt_idx = 1'b0;
    end else if (valid == 2'b10) begin
      gnt_idx = 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_grant
      assign grant[gi] = valid[gi] & (gnt_idx == 1'(gi));
    end
  endgenerate

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the execute stage (port 0) and the
// branch/compare unit (port 1) with round-robin arbitration and a response channel.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  alu_share_arbiter_if.slave    bus,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [OP_W-1:0]       alu_op,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  alu_zero,
  output logic                  busy,
  output logic [1:0][CNT_W-1:0] grant_cnt
);

  arb_state_e        state_reg, state_next;
  logic              rr_ptr_reg;
  logic              owner_reg;
  logic [OP_W-1:0]   op_reg;
  logic [DATA_W-1:0] a_reg, b_reg;
  logic [DATA_W-1:0] rsp_data_reg;
  logic              rsp_zero_reg;
  logic [1:0]        grant;
  logic              gnt_idx;
  logic              accept;

  rr_arb2 u_arb (
    .valid   (bus.req_valid),
    .ptr     (rr_ptr_reg),
    .grant   (grant),
    .gnt_idx (gnt_idx)
  );

  assign accept = (state_reg == IDLE) && (|bus.req_valid);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (bus.rsp_ready[owner_reg]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    busy          = (state_reg != IDLE);
    if (state_reg == IDLE) begin
      bus.req_ready = grant;
    end
    if (state_reg == RESP) begin
      bus.rsp_valid[owner_reg] = 1'b1;
    end
  end

  // Operands are held in registers so the ALU never sees requester-side glitches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_reg       <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      owner_reg    <= 1'b0;
      rr_ptr_reg   <= 1'b0;
      rsp_data_reg <= '0;
      rsp_zero_reg <= 1'b0;
    end else begin
      if (accept) begin
        op_reg     <= bus.req_op[gnt_idx];
        a_reg      <= bus.req_a[gnt_idx];
        b_reg      <= bus.req_b[gnt_idx];
        owner_reg  <= gnt_idx;
        rr_ptr_reg <= ~gnt_idx;
      end
      if (state_reg == EXEC) begin
        rsp_data_reg <= alu_result;
        rsp_zero_reg <= alu_zero;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_reg <= '0;
        end else if (accept && (gnt_idx == 1'(gi)) && (cnt_reg != '1)) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign grant_cnt[gi] = cnt_reg;
    end
  endgenerate

  assign alu_a        = a_reg;
  assign alu_b        = b_reg;
  assign alu_op       = op_reg;
  assign bus.rsp_data = rsp_data_reg;
  assign bus.rsp_zero = rsp_zero_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a default build and a CNT_W=4 build share one stimulus.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]             req_valid = '0;
  logic [1:0]             rsp_ready = '0;
  logic [1:0][OP_W-1:0]   req_op = '0;
  logic [1:0][DATA_W-1:0] req_a = '0;
  logic [1:0][DATA_W-1:0] req_b = '0;

  int n_checks = 0;
  int n_errors = 0;

  alu_share_arbiter_if bus_d ();
  alu_share_arbiter_if bus_s ();

  assign bus_d.req_valid = req_valid;
  assign bus_d.req_op    = req_op;
  assign bus_d.req_a     = req_a;
  assign bus_d.req_b     = req_b;
  assign bus_d.rsp_ready = rsp_ready;
  assign bus_s.req_valid = req_valid;
  assign bus_s.req_op    = req_op;
  assign bus_s.req_a     = req_a;
  assign bus_s.req_b     = req_b;
  assign bus_s.rsp_ready = rsp_ready;

  logic [DATA_W-1:0] d_alu_a, d_alu_b, d_alu_result;
  logic [OP_W-1:0]   d_alu_op;
  logic              d_alu_zero, d_busy;
  logic [1:0][15:0]  d_cnt;
  logic [DATA_W-1:0] s_alu_a, s_alu_b, s_alu_result;
  logic [OP_W-1:0]   s_alu_op;
  logic              s_alu_zero, s_busy;
  logic [1:0][3:0]   s_cnt;

  // Behavioural ALU standing in for the real instance.
  function automatic logic [DATA_W:0] alu_model(input logic [OP_W-1:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] sum;
    sum = a + b;
    case (op)
      AND:     r = a & b;
      ADD:     r = sum;
      XOR:     r = a ^ b;
      SLT:     r = {7'd0, (a < b)};
      SLL:     r = a << b[2:0];
      SRL:     r = a >> b[2:0];
      SNE:     r = {7'd0, (a != b)};
      default: r = {7'd0, (a[7] == b[7]) && (sum[7] != a[7])};
    endcase
    return {(r == '0), r};
  endfunction

  assign {d_alu_zero, d_alu_result} = alu_model(d_alu_op, d_alu_a, d_alu_b);
  assign {s_alu_zero, s_alu_result} = alu_model(s_alu_op, s_alu_a, s_alu_b);

  alu_share_arbiter u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus_d.slave),
    .alu_a      (d_alu_a),
    .alu_b      (d_alu_b),
    .alu_op     (d_alu_op),
    .alu_result (d_alu_result),
    .alu_zero   (d_alu_zero),
    .busy       (d_busy),
    .grant_cnt  (d_cnt)
  );

  alu_share_arbiter #(.CNT_W(4)) u_sat (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus_s.slave),
    .alu_a      (s_alu_a),
    .alu_b      (s_alu_b),
    .alu_op     (s_alu_op),
    .alu_result (s_alu_result),
    .alu_zero   (s_alu_zero),
    .busy       (s_busy),
    .grant_cnt  (s_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Starts at the accept cycle (negedge + 1) and runs EXEC, RESP and the handshake.
  task automatic finish_op(input int port, input logic [7:0] exp_data, input logic exp_zero);
    @(negedge clk);
    req_valid[port] = 1'b0;
    #1;
    check("exec_busy", d_busy, 1);
    check("exec_rsp_valid", bus_d.rsp_valid, 0);
    check("exec_req_ready", bus_d.req_ready, 0);
    @(negedge clk);
    #1;
    check("resp_busy", d_busy, 1);
    check("rsp_valid", bus_d.rsp_valid, 32'd1 << port);
    check("rsp_data", bus_d.rsp_data, exp_data);
    check("rsp_zero", bus_d.rsp_zero, exp_zero);
    check("sat_rsp_valid", bus_s.rsp_valid, 32'd1 << port);
    check("sat_rsp_data", bus_s.rsp_data, exp_data);
    rsp_ready[port] = 1'b1;
    @(negedge clk);
    rsp_ready[port] = 1'b0;
    #1;
    check("idle_busy", d_busy, 0);
    check("idle_rsp_valid", bus_d.rsp_valid, 0);
    $display("txn port=%0d rsp_data=0x%02h rsp_zero=%0b", port, bus_d.rsp_data, bus_d.rsp_zero);
  endtask

  task automatic run_op(input int port, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp_data, input logic exp_zero);
    @(negedge clk);
    req_op[port]    = op;
    req_a[port]     = a;
    req_b[port]     = b;
    req_valid[port] = 1'b1;
    #1;
    for (int k = 0; k < 20 && bus_d.req_ready[port] !== 1'b1; k++) begin
      @(negedge clk);
      #1;
    end
    check("req_ready", bus_d.req_ready, 32'd1 << port);
    finish_op(port, exp_data, exp_zero);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    @(negedge clk);
    #1;
    check("rst_busy", d_busy, 0);
    check("rst_req_ready", bus_d.req_ready, 0);
    check("rst_rsp_valid", bus_d.rsp_valid, 0);
    check("rst_rsp_data", bus_d.rsp_data, 0);
    check("rst_rsp_zero", bus_d.rsp_zero, 0);
    check("rst_cnt", d_cnt, 0);
    check("rst_alu", {d_alu_a, d_alu_b, 5'd0, d_alu_op}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Port 0 only, then port 1 only
    run_op(0, ADD, 8'h05, 8'h03, 8'h08, 1'b0);
    check("t1_cnt0", d_cnt[0], 1);
    run_op(1, AND, 8'hF0, 8'h0F, 8'h00, 1'b1);
    check("t2_cnt1", d_cnt[1], 1);

    // Both valid from reset
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    req_op[0] = ADD; req_a[0] = 8'hFF; req_b[0] = 8'h02;
    req_op[1] = SLT; req_a[1] = 8'h03; req_b[1] = 8'h07;
    req_valid = 2'b11;
    #1;
    check("pair1_ready", bus_d.req_ready, 2'b01);
    finish_op(0, 8'h01, 1'b0);
    check("pair1_loser_ready", bus_d.req_ready, 2'b10);
    finish_op(1, 8'h01, 1'b0);
    req_op[0] = XOR; req_a[0] = 8'hAA; req_b[0] = 8'h55;
    req_op[1] = SNE; req_a[1] = 8'h04; req_b[1] = 8'h04;
    req_valid = 2'b11;
    #1;
    check("pair3_ready", bus_d.req_ready, 2'b01);
    finish_op(0, 8'hFF, 1'b0);
    check("pair3_loser_ready", bus_d.req_ready, 2'b10);
    finish_op(1, 8'h00, 1'b1);
    check("pair_cnt", d_cnt, {16'd2, 16'd2});

    // Backpressure on port 0 while port 1 waits
    @(negedge clk);
    req_op[0] = SLL; req_a[0] = 8'h03; req_b[0] = 8'h02;
    req_op[1] = SRL; req_a[1] = 8'h80; req_b[1] = 8'h03;
    req_valid = 2'b11;
    #1;
    check("bp_ready", bus_d.req_ready, 2'b01);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    #1;
    for (int c = 0; c < 10; c++) begin
      rsp_ready[1] = (c >= 3 && c < 7);
      #1;
      check("bp_rsp_valid", bus_d.rsp_valid, 2'b01);
      check("bp_rsp_data", bus_d.rsp_data, 8'h0C);
      check("bp_busy", d_busy, 1);
      check("bp_req_ready", bus_d.req_ready, 0);
      @(negedge clk);
      #1;
    end
    rsp_ready[1] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    #1;
    check("bp_release_ready", bus_d.req_ready, 2'b10);
    finish_op(1, 8'h10, 1'b0);
    $display("txn port=0 rsp_data=0x0c (held 10 cycles under backpressure)");

    // Reset in the middle of EXEC
    @(negedge clk);
    req_op[0] = ADD; req_a[0] = 8'h01; req_b[0] = 8'h01;
    req_valid[0] = 1'b1;
    #1;
    check("mid_ready", bus_d.req_ready, 2'b01);
    @(negedge clk);
    req_valid[0] = 1'b0;
    #1;
    check("mid_exec_busy", d_busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_busy", d_busy, 0);
    check("mid_rsp_valid", bus_d.rsp_valid, 0);
    check("mid_rsp_data", bus_d.rsp_data, 0);
    check("mid_rsp_zero", bus_d.rsp_zero, 0);
    check("mid_alu_a", d_alu_a, 0);
    check("mid_cnt", d_cnt, 0);
    check("mid_sat_rsp_data", bus_s.rsp_data, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check("post_rst_rsp_valid", bus_d.rsp_valid, 0);
    end
    run_op(1, OVF, 8'h7F, 8'h01, 8'h01, 1'b0);
    check("post_rst_cnt", d_cnt, {16'd1, 16'd0});

    // Saturation of the 4-bit counter build
    for (int i = 0; i < 17; i++) begin
      run_op(0, ADD, 8'(i), 8'h01, 8'(i + 1), 1'b0);
      if (i == 14) check("sat_cnt_at_15", s_cnt[0], 4'hF);
    end
    check("sat_cnt0", s_cnt[0], 4'hF);
    check("sat_cnt1", s_cnt[1], 4'h1);
    check("wide_cnt0", d_cnt[0], 16'd17);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
